// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand/result width
package subtrator_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/subtratorcompleto.sv
// 1-bit full subtractor cell: computes a - b - cin.
// Ports:
//   a, b  : operand bits
//   cin   : borrow in
//   s     : difference bit
//   cout  : borrow out
module subtratorcompleto (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (~a & b) | (~a & cin) | (b & cin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   start  : begin an operation (sampled only in IDLE)
//   a, b   : minuend / subtrahend, latched on the accepted start edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result valid
//   diff   : (a - b) mod 2^WIDTH
//   borrow : final borrow-out, 1 iff a < b
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  sa_q;
    logic [WIDTH-1:0]  sb_q;
    logic [WIDTH-1:0]  diff_q;
    logic              borrow_q;
    logic [CW-1:0]     cnt_q;

    logic              cell_s_d;
    logic              cell_borrow_d;

    subtratorcompleto u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .cin  (borrow_q),
        .s    (cell_s_d),
        .cout (cell_borrow_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        diff_q   <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    // Result bits enter at the MSB so bit 0 lands at diff[0] after WIDTH shifts.
                    diff_q   <= {cell_s_d, diff_q[WIDTH-1:1]};
                    borrow_q <= cell_borrow_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_subtrator_serial.sv
module tb_subtrator_serial;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow;
    logic [W-1:0] diff;

    logic         start3;
    logic [2:0]   a3, b3;
    logic         busy3, done3, borrow3;
    logic [2:0]   diff3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    subtrator_serial #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    subtrator_serial #(.WIDTH(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .start  (start3),
        .a      (a3),
        .b      (b3),
        .busy   (busy3),
        .done   (done3),
        .diff   (diff3),
        .borrow (borrow3)
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on the 8-bit DUT with timing and hold checks.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ed, input logic eb);
        int cycles;
        int busy_cnt;
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 50) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
        check("latency", cycles, W);
        check("busy_cycles", busy_cnt, W);
        check("done_busy_low", int'(busy), 0);
        check("diff", int'(diff), int'(ed));
        check("borrow", int'(borrow), int'(eb));
        tick();
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        tick();
        check("diff_hold", int'(diff), int'(ed));
        check("borrow_hold", int'(borrow), int'(eb));
    endtask

    initial begin
        int ndone;
        int last;
        int cyc;
        logic [W-1:0] got_d;
        logic         got_b;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        start3 = 1'b0;
        a3 = '0;
        b3 = '0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_borrow", int'(borrow), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();

        vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
        vecs[1] = '{8'd10,  8'd20,  8'd246, 1'b1};
        vecs[2] = '{8'd0,   8'd255, 8'd1,   1'b1};
        vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
        vecs[4] = '{8'd128, 8'd1,   8'd127, 1'b0};
        vecs[5] = '{8'd1,   8'd128, 8'd129, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_borrow);
        end

        // Operand isolation and start rejection while running.
        a = 8'd100;
        b = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        got_d = '0;
        got_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ndone++;
                got_d = diff;
                got_b = borrow;
            end
            tick();
        end
        check("iso_done_count", ndone, 1);
        check("iso_diff", int'(got_d), 99);
        check("iso_borrow", int'(got_b), 0);

        // Continuous start: one result every WIDTH+2 cycles.
        a = 8'd7;
        b = 8'd3;
        start = 1'b1;
        ndone = 0;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done && busy) check("done_and_busy", 1, 0);
            if (done) begin
                ndone++;
                check("cont_diff", int'(diff), 4);
                if (last >= 0) check("cont_period", i - last, W + 2);
                last = i;
            end
        end
        check("cont_done_count", ndone, 4);
        start = 1'b0;
        cyc = 0;
        while ((busy || done) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("cont_drain", int'(busy || done), 0);
        tick();

        // Asynchronous reset in the middle of RUN (after bit 4 is processed).
        a = 8'd200;
        b = 8'd55;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_diff", int'(diff), 0);
        check("arst_borrow", int'(borrow), 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("post_rst_quiet", ndone, 0);
        run_op(8'd5, 8'd9, 8'd252, 1'b1);

        // Exhaustive 3-bit check against (a - b) & 7 and a < b.
        ndone = 0;
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                a3 = 3'(x);
                b3 = 3'(y);
                start3 = 1'b1;
                tick();
                start3 = 1'b0;
                cyc = 0;
                while (!done3 && cyc < 20) begin
                    tick();
                    cyc++;
                end
                tests++;
                if (!done3 || int'(diff3) != ((x - y) & 7) || int'(borrow3) != int'(x < y)) begin
                    fails++;
                    $display("FAIL w3 a=%0d b=%0d: got diff=%0d borrow=%0d done=%0d, expected diff=%0d borrow=%0d",
                             x, y, diff3, borrow3, done3, (x - y) & 7, int'(x < y));
                end
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
